// File: rtl/pe_mac_sat.sv
// pe_mac_sat: systolic-array processing element.
// Operands move through the element with a one-cycle register stage (up->down, left->right).
// An operation starts on start_i. It then accumulates N signed products up_i*left_i into a
// wide accumulator. Each add either wraps or saturates. Overflow is reported on a sticky flag.
// The finished sum is presented on res_o with a one-cycle res_valid_o strobe.
module pe_mac_sat #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ACC_WIDTH  = 64,
    parameter  int MAX_DIM    = 8,
    localparam int CNT_W      = $clog2(MAX_DIM + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      len_i,
    input  logic                  mode_i,
    input  logic                  sat_i,
    input  logic [ACC_WIDTH-1:0]  c_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] up_i,
    input  logic [DATA_WIDTH-1:0] left_i,
    output logic [DATA_WIDTH-1:0] down_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  valid_o,
    output logic [ACC_WIDTH-1:0]  res_o,
    output logic                  res_valid_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    // Clamp limits of the signed accumulator.
    localparam logic [ACC_WIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]     MAX_LEN_C = CNT_W'(MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed add with overflow detect. Returns {overflow, result}.
    // The two operands having equal signs and the sum having a different sign means overflow.
    // With saturation enabled, the result is pinned in the direction the operands pointed.
    function automatic logic [ACC_WIDTH:0] add_sat(
        input logic [ACC_WIDTH-1:0] a,
        input logic [ACC_WIDTH-1:0] b,
        input logic                 sat
    );
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
        sum = a + b;
        ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
        if (ovf && sat) begin
            if (a[ACC_WIDTH-1]) begin
                sum = ACC_MIN;
            end else begin
                sum = ACC_MAX;
            end
        end else begin
            sum = sum;
        end
        return {ovf, sum};
    endfunction

    // A zero length or an out-of-range length means a full MAX_DIM-long operation.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] r;
        if ((len == {CNT_W{1'b0}}) || (len > MAX_LEN_C)) begin
            r = MAX_LEN_C;
        end else begin
            r = len;
        end
        return r;
    endfunction

    state_t                       state_r;
    logic [ACC_WIDTH-1:0]         acc_r;
    logic [CNT_W-1:0]             count_r;
    logic [CNT_W-1:0]             len_r;
    logic                         sat_r;

    logic signed [PROD_W-1:0]     up_ext_s;
    logic signed [PROD_W-1:0]     left_ext_s;
    logic signed [PROD_W-1:0]     prod_s;
    logic signed [ACC_WIDTH-1:0]  prod_ext_s;
    logic [ACC_WIDTH-1:0]         acc_next_s;
    logic                         ovf_s;
    logic [CNT_W-1:0]             count_next_s;
    logic                         last_s;
    logic                         launch_s;

    // Product and accumulate datapath. The product is formed at full 2*DATA_WIDTH precision and
    // then sign-extended before the add.
    always_comb begin
        up_ext_s      = PROD_W'($signed(up_i));
        left_ext_s    = PROD_W'($signed(left_i));
        prod_s        = up_ext_s * left_ext_s;
        prod_ext_s    = ACC_WIDTH'(prod_s);
        {ovf_s, acc_next_s} = add_sat(acc_r, prod_ext_s, sat_r);
        count_next_s  = count_r + CNT_W'(1);
        last_s        = (count_next_s == len_r);
        launch_s      = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    end

    // Operand pass-through to the neighbouring elements. It runs every cycle, whatever the FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            down_o  <= {DATA_WIDTH{1'b0}};
            right_o <= {DATA_WIDTH{1'b0}};
            valid_o <= 1'b0;
        end else begin
            down_o  <= up_i;
            right_o <= left_i;
            valid_o <= valid_i;
        end
    end

    // Operation control: launch, accumulate on valid operands, publish the result, and return to idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            len_r       <= {CNT_W{1'b0}};
            sat_r       <= 1'b0;
            res_o       <= {ACC_WIDTH{1'b0}};
            res_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else if (launch_s) begin
            // The mode only selects the starting bias, so it is not kept past this edge.
            state_r     <= ST_ACC;
            acc_r       <= mode_i ? c_i : {ACC_WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            len_r       <= eff_len(len_i);
            sat_r       <= sat_i;
            res_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            busy_o      <= 1'b1;
        end else begin
            res_valid_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                ST_ACC: begin
                    // A cycle without valid_i is a stall. Nothing moves and there is no timeout.
                    if (valid_i) begin
                        acc_r      <= acc_next_s;
                        count_r    <= count_next_s;
                        overflow_o <= overflow_o | ovf_s;
                        if (last_s) begin
                            state_r     <= ST_DONE;
                            res_o       <= acc_next_s;
                            res_valid_o <= 1'b1;
                            busy_o      <= 1'b0;
                        end else begin
                            state_r <= ST_ACC;
                            busy_o  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_ACC;
                        busy_o  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_sat.sv
// Bench for pe_mac_sat. Two instances share one stimulus stream:
// - a default 32/64 instance;
// - an 8/16 instance that sees the low bits of the same stimulus.
// A mathematical reference model computes the expected outputs with wide integer arithmetic and
// explicit range checks. One compare process checks both instances on every falling edge.
// Directed sequences add hand-computed literal expectations.
module tb_pe_mac_sat;

    localparam int CW   = 4;
    localparam int MAXD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, start_i, mode_i, sat_i, valid_i;
    logic [CW-1:0] len_i;
    logic [63:0]   c_i;
    logic [31:0]   up_i, left_i;

    logic [31:0] a_down, a_right;
    logic        a_valid, a_rv, a_ovf, a_busy;
    logic [63:0] a_res;
    logic [7:0]  b_down, b_right;
    logic        b_valid, b_rv, b_ovf, b_busy;
    logic [15:0] b_res;

    pe_mac_sat u_dut_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
        .sat_i(sat_i), .c_i(c_i), .valid_i(valid_i), .up_i(up_i), .left_i(left_i),
        .down_o(a_down), .right_o(a_right), .valid_o(a_valid), .res_o(a_res),
        .res_valid_o(a_rv), .overflow_o(a_ovf), .busy_o(a_busy)
    );

    pe_mac_sat #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_DIM(8)) u_dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
        .sat_i(sat_i), .c_i(c_i[15:0]), .valid_i(valid_i), .up_i(up_i[7:0]), .left_i(left_i[7:0]),
        .down_o(b_down), .right_o(b_right), .valid_o(b_valid), .res_o(b_res),
        .res_valid_o(b_rv), .overflow_o(b_ovf), .busy_o(b_busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state. Index 0 is the 32/64 instance and index 1 is the 8/16 instance.
    int                  m_aw[2] = '{64, 16};
    int                  m_dw[2] = '{32, 8};
    int                  m_phase[2] = '{0, 0};   // 0 idle, 1 accumulating, 2 result cycle
    int                  m_n[2], m_cnt[2];
    bit                  m_sat[2], m_rv[2], m_ovf[2], m_busy[2];
    logic signed [127:0] m_acc[2], m_res[2];
    logic [31:0]         e_up, e_left;
    logic                e_valid;

    // Take the low w bits of v and interpret them as a signed w-bit integer.
    function automatic logic signed [127:0] sx(input logic [127:0] v, input int w);
        logic [127:0]        mask, half;
        logic signed [127:0] r;
        mask = (128'd1 << w) - 128'd1;
        half = 128'd1 << (w - 1);
        r = $signed(v & mask);
        if ((v & mask) >= half) r = r - $signed(128'd1 << w);
        return r;
    endfunction

    task automatic model_step(input int k);
        logic signed [127:0] s, hi, lo;
        int ln;
        if (rst_i) begin
            m_phase[k] = 0; m_acc[k] = 128'sd0; m_cnt[k] = 0; m_res[k] = 128'sd0;
            m_rv[k] = 1'b0; m_ovf[k] = 1'b0; m_busy[k] = 1'b0;
        end else begin
            m_rv[k] = 1'b0;
            if (start_i && m_phase[k] != 1) begin
                ln = int'(len_i);
                m_n[k]     = (ln == 0 || ln > MAXD) ? MAXD : ln;
                m_acc[k]   = mode_i ? sx({64'd0, c_i}, m_aw[k]) : 128'sd0;
                m_cnt[k]   = 0;
                m_ovf[k]   = 1'b0;
                m_sat[k]   = sat_i;
                m_phase[k] = 1;
            end else if (m_phase[k] == 1) begin
                if (valid_i) begin
                    s  = m_acc[k] + sx({96'd0, up_i}, m_dw[k]) * sx({96'd0, left_i}, m_dw[k]);
                    hi = (128'sd1 <<< (m_aw[k] - 1)) - 128'sd1;
                    lo = -(128'sd1 <<< (m_aw[k] - 1));
                    if (s > hi || s < lo) begin
                        m_ovf[k] = 1'b1;
                        if (m_sat[k]) s = (s > hi) ? hi : lo;
                        else          s = sx(s, m_aw[k]);
                    end
                    m_acc[k] = s;
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == m_n[k]) begin
                        m_res[k] = s; m_rv[k] = 1'b1; m_phase[k] = 2;
                    end
                end
            end else begin
                m_phase[k] = 0;
            end
            m_busy[k] = (m_phase[k] == 1);
        end
    endtask

    // Advance the reference model on every rising edge, using the same inputs the DUTs sample.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst_i) begin
            e_up = 32'd0; e_left = 32'd0; e_valid = 1'b0;
        end else begin
            e_up = up_i; e_left = left_i; e_valid = valid_i;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_down",  a_down,  e_up);
            chk("a_right", a_right, e_left);
            chk("a_valid", a_valid, e_valid);
            chk("a_res",   a_res,   m_res[0][63:0]);
            chk("a_rv",    a_rv,    m_rv[0]);
            chk("a_ovf",   a_ovf,   m_ovf[0]);
            chk("a_busy",  a_busy,  m_busy[0]);
            chk("b_down",  b_down,  e_up[7:0]);
            chk("b_right", b_right, e_left[7:0]);
            chk("b_valid", b_valid, e_valid);
            chk("b_res",   b_res,   m_res[1][15:0]);
            chk("b_rv",    b_rv,    m_rv[1]);
            chk("b_ovf",   b_ovf,   m_ovf[1]);
            chk("b_busy",  b_busy,  m_busy[1]);
        end
    end

    task automatic drive(input bit st, input logic [CW-1:0] ln, input bit md, input bit sa,
                         input logic [63:0] c, input bit v, input logic [31:0] u, input logic [31:0] l);
        start_i = st; len_i = ln; mode_i = md; sat_i = sa; c_i = c;
        valid_i = v; up_i = u; left_i = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [31:0] u, input logic [31:0] l);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 1'b1, u, l);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
    endtask

    logic [31:0] ru, rl;
    logic [7:0]  r8;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = 4'd0; mode_i = 1'b0; sat_i = 1'b0;
        c_i = 64'd0; valid_i = 1'b0; up_i = 32'd0; left_i = 32'd0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk("rst_res",  a_res,  64'd0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_rv",   a_rv,   1'b0);
        rst_i = 1'b0;

        // N=3, plain sum: 6 - 20 + 7 = -7
        drive(1'b1, 4'd3, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
        chk("start_busy", a_busy, 1'b1);
        op(32'd2, 32'd3); op(-32'sd4, 32'd5); op(32'd7, 32'd1);
        chk("r021_rv",    a_rv,  1'b1);
        chk("r021_res",   a_res, 64'hFFFF_FFFF_FFFF_FFF9);
        chk("r021_ovf",   a_ovf, 1'b0);
        chk("r021_b_res", b_res, 16'hFFF9);
        chk("r021_model", m_res[0][63:0], 64'hFFFF_FFFF_FFFF_FFF9);
        idle();
        chk("r021_rv_off", a_rv,  1'b0);
        chk("r021_hold",   a_res, 64'hFFFF_FFFF_FFFF_FFF9);

        // N=2 with bias 100 and a two-cycle bubble: 100 + 12 - 30 = 82
        drive(1'b1, 4'd2, 1'b1, 1'b0, 64'd100, 1'b0, 32'd0, 32'd0);
        op(32'd3, 32'd4);
        idle(); chk("r022_bub1", a_busy, 1'b1);
        idle(); chk("r022_bub2", a_busy, 1'b1);
        op(-32'sd5, 32'd6);
        chk("r022_res", a_res, 64'd82);
        chk("r022_rv",  a_rv,  1'b1);

        // 8/16 instance, three 127*127 products, saturating then wrapping (back-to-back start)
        drive(1'b1, 4'd3, 1'b0, 1'b1, 64'd0, 1'b0, 32'd0, 32'd0);
        op(32'd127, 32'd127); op(32'd127, 32'd127); op(32'd127, 32'd127);
        chk("r023_sat_res", b_res, 16'h7FFF);
        chk("r023_sat_ovf", b_ovf, 1'b1);
        chk("r023_a_res",   a_res, 64'd48387);
        drive(1'b1, 4'd3, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
        chk("b2b_busy",  a_busy, 1'b1);
        chk("b2b_ovf_clr", b_ovf, 1'b0);
        op(32'd127, 32'd127); op(32'd127, 32'd127); op(32'd127, 32'd127);
        chk("r023_wrap_res", b_res, 16'hBD03);
        chk("r023_wrap_ovf", b_ovf, 1'b1);
        chk("r023_model",    m_res[1][15:0], 16'hBD03);

        // Reset in the middle of an N=4 operation, then a fresh N=1 operation
        idle();
        drive(1'b1, 4'd4, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
        op(32'd1, 32'd2); op(32'd3, 32'd4);
        rst_i = 1'b1;
        drive(1'b1, 4'd1, 1'b0, 1'b0, 64'd0, 1'b1, 32'd5, 32'd5);
        rst_i = 1'b0;
        chk("r025_res",   a_res,   64'd0);
        chk("r025_rv",    a_rv,    1'b0);
        chk("r025_busy",  a_busy,  1'b0);
        chk("r025_valid", a_valid, 1'b0);
        chk("r025_down",  a_down,  32'd0);
        drive(1'b1, 4'd1, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
        op(32'd6, 32'd7);
        chk("r025_res42", a_res, 64'd42);
        chk("r025_rv42",  a_rv,  1'b1);

        // start_i during accumulation is ignored (the operand on that cycle still counts)
        idle();
        drive(1'b1, 4'd2, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
        op(32'd1, 32'd1);
        drive(1'b1, 4'd5, 1'b1, 1'b0, 64'd1000, 1'b1, 32'd2, 32'd2);
        chk("r026_ign_res", a_res, 64'd5);
        chk("r026_ign_rv",  a_rv,  1'b1);

        // len_i=0 and len_i>MAX_DIM both require MAX_DIM operands
        for (int t = 0; t < 2; t++) begin
            idle();
            drive(1'b1, (t == 0) ? 4'd0 : 4'd15, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 32'd0);
            for (int j = 0; j < 7; j++) op(32'd1, 32'd1);
            chk("r026_len_busy", a_busy, 1'b1);
            chk("r026_len_rv0",  a_rv,   1'b0);
            op(32'd1, 32'd1);
            chk("r026_len_res",  a_res,  64'd8);
            chk("r026_len_rv",   a_rv,   1'b1);
        end

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0: ru = $urandom;
                1: begin r8 = 8'($urandom); ru = {{24{r8[7]}}, r8}; end
                default: ru = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            endcase
            case ($urandom_range(0, 2))
                0: rl = $urandom;
                1: begin r8 = 8'($urandom); rl = {{24{r8[7]}}, r8}; end
                default: rl = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            endcase
            rst_i = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 1'($urandom),
                  1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0, ru, rl);
        end
        rst_i = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_mac_sat.md
PE_MAC_SAT -- requirements
Module: pe_mac_sat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed operand width.
REQ-002 SHALL have parameter ACC_WIDTH, default 64, signed accumulator/result width; legal only if ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter MAX_DIM, default 8, maximum products per operation; CNT_W = $clog2(MAX_DIM+1).
REQ-004 SHALL have ports:
  clk_i  in  1  clock, all logic on rising edge.
  rst_i  in  1  synchronous, active-high reset.
  start_i  in  1  begins an operation.
  len_i  in  CNT_W  product count N, captured at start.
  mode_i  in  1  0: result = sum; 1: result = c_i + sum; captured at start.
  sat_i  in  1  1: saturating accumulate; 0: wrap; captured at start.
  c_i  in  ACC_WIDTH  signed bias, captured at start.
  valid_i  in  1  up_i/left_i pair valid.
  up_i, left_i  in  DATA_WIDTH  signed operands.
  down_o, right_o  out  DATA_WIDTH  registered forward of up_i, left_i.
  valid_o  out  1  registered forward of valid_i.
  res_o  out  ACC_WIDTH  signed result, registered.
  res_valid_o  out  1  one-cycle result strobe.
  overflow_o  out  1  sticky overflow flag for the current/last operation.
  busy_o  out  1  high in ACC state.

Function
REQ-005 SHALL forward down_o<=up_i, right_o<=left_i, valid_o<=valid_i every cycle in every state (1-cycle latency, independent of FSM).
REQ-006 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE; busy_o=1 only in ACC.
REQ-007 IDLE, start_i=1: capture len/mode/sat; acc<=mode_i?c_i:0; count<=0; overflow_o<=0; go ACC.
REQ-008 len_i=0 or len_i>MAX_DIM SHALL be treated as MAX_DIM.
REQ-009 Operands SHALL be accepted only in ACC with valid_i=1; valid_i in the start cycle is forwarded but not accumulated.
REQ-010 ACC, valid_i=0: hold acc, count, state (stall, no timeout).
REQ-011 Accept: product = up_i*left_i, full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; acc<=acc+product same edge; count<=count+1.
REQ-012 Signed overflow SHALL be detected on every add (operand signs equal, sum sign differs), including c_i+first product.
REQ-013 On overflow: sat=1 clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) by direction; sat=0 keep wrapped sum; both set overflow_o=1 until next start or reset.
REQ-014 Saturated acc SHALL continue accumulating from the clamped value (can move back in range).
REQ-015 Edge accepting the Nth operand: res_o<=final acc, go DONE; res_valid_o=1 exactly in the DONE cycle (1 cycle after last operand sampled).
REQ-016 res_o SHALL hold its value until next result or reset.
REQ-017 DONE, start_i=1: start new operation per REQ-007 (back-to-back); else go IDLE.
REQ-018 start_i in ACC SHALL be ignored; operation continues unaffected.

Reset
REQ-019 rst_i=1 at an edge SHALL force state IDLE, acc=0, count=0 and all outputs (down_o, right_o, valid_o, res_o, res_valid_o, overflow_o, busy_o) to 0, overriding any start_i/valid_i.
REQ-020 Reset mid-ACC SHALL abandon the operation with no res_valid_o; next start_i after release SHALL behave normally.

Verification
REQ-021 N=3, mode=0, sat=0, operands (2,3),(-4,5),(7,1) consecutive -> res_o=-7, res_valid_o one cycle after 3rd, overflow_o=0.
REQ-022 N=2, mode=1, c_i=100, (3,4), valid_i=0 two cycles, (-5,6) -> res_o=82, busy_o high through bubble.
REQ-023 DATA_WIDTH=8, ACC_WIDTH=16, N=3, three (127,127): sat=1 -> res_o=32767, overflow_o=1; sat=0 -> res_o=-17149, overflow_o=1.
REQ-024 Random up_i/left_i/valid_i in IDLE, ACC, DONE -> down_o/right_o/valid_o equal prior-cycle inputs.
REQ-025 rst_i after 2 of N=4 operands -> all outputs 0 next cycle, no res_valid_o; new N=1 (6,7) -> res_o=42.
REQ-026 start_i in DONE -> immediate new operation; start_i in ACC -> ignored, result unchanged; len_i=0 -> MAX_DIM operands needed.
